// File: rtl/adder_pkg.sv
// Shared constants, slice-width helper and per-stage carry/valid record for pipelined_adder.
// Optional signed-overflow output is enabled by defining ADDER_OVERFLOW_EN.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

  // Guard against a zero stage count so the elaboration check can report it cleanly.
  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  typedef struct packed {
    logic carry;
    logic valid;
  } stage_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; ovf exists only with ADDER_OVERFLOW_EN.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef ADDER_OVERFLOW_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef ADDER_OVERFLOW_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/adder_slice.sv
// One carry-chain slice: SW-bit add with carry-in, registered sum and carry/valid record.
// With ADDER_OVERFLOW_EN the final slice also registers signed overflow.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SW = 4
`ifdef ADDER_OVERFLOW_EN
  , parameter bit LAST = 1'b0
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  stage_t        prev,
  output logic [SW-1:0] sum,
  output stage_t        st
`ifdef ADDER_OVERFLOW_EN
  , output logic        ovf
`endif
);

  logic [SW:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, prev.carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      st  <= '0;
    end else if (en) begin
      sum      <= full[SW-1:0];
      st.carry <= full[SW];
      st.valid <= prev.valid;
    end
  end

`ifdef ADDER_OVERFLOW_EN
  logic msb_cin;

  // Carry into the MSB recovered from the sum bit; only the top slice's MSB is the word MSB.
  assign msb_cin = a[SW-1] ^ b[SW-1] ^ full[SW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (en) begin
      ovf <= LAST ? (msb_cin ^ full[SW]) : 1'b0;
    end
  end
`endif

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with the carry chain split over STAGES registered slices and a
// single global advance enable for backpressure. Define ADDER_OVERFLOW_EN for the ovf output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic             clk,
  input logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic          adv;
  logic          out_valid_q;
  logic [SW-1:0] op_a  [STAGES];
  logic [SW-1:0] op_b  [STAGES];
  logic [SW-1:0] sum_s [STAGES];
  stage_t        st_in  [STAGES];
  stage_t        st_out [STAGES];
  logic [WIDTH-1:0] sum_aligned;
`ifdef ADDER_OVERFLOW_EN
  logic [STAGES-1:0] ovf_s;
`endif

  // The whole pipeline moves together: it advances unless a finished result is being held.
  assign out_valid_q   = st_out[STAGES-1].valid;
  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_aligned;
  assign bus.cout      = st_out[STAGES-1].carry;
`ifdef ADDER_OVERFLOW_EN
  assign bus.ovf       = |ovf_s;
`endif

  assign st_in[0] = '{carry: bus.cin, valid: bus.in_valid};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage

    if (k == 0) begin : g_direct
      assign op_a[k] = bus.a[k*SW +: SW];
      assign op_b[k] = bus.b[k*SW +: SW];
    end else begin : g_skew
      logic [SW-1:0] a_sk [k];
      logic [SW-1:0] b_sk [k];

      // Slice k's operands wait k loads so they meet the carry coming up the chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_sk[j] <= '0;
            b_sk[j] <= '0;
          end
        end else if (adv) begin
          a_sk[0] <= bus.a[k*SW +: SW];
          b_sk[0] <= bus.b[k*SW +: SW];
          for (int j = 1; j < k; j++) begin
            a_sk[j] <= a_sk[j-1];
            b_sk[j] <= b_sk[j-1];
          end
        end
      end

      assign op_a[k]  = a_sk[k-1];
      assign op_b[k]  = b_sk[k-1];
      assign st_in[k] = st_out[k-1];
    end

    adder_slice #(
      .SW   (SW)
`ifdef ADDER_OVERFLOW_EN
      , .LAST (k == STAGES-1)
`endif
    ) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .a     (op_a[k]),
      .b     (op_b[k]),
      .prev  (st_in[k]),
      .sum   (sum_s[k]),
      .st    (st_out[k])
`ifdef ADDER_OVERFLOW_EN
      , .ovf (ovf_s[k])
`endif
    );

    if (k == STAGES-1) begin : g_no_deskew
      assign sum_aligned[k*SW +: SW] = sum_s[k];
    end else begin : g_deskew
      localparam int D = STAGES - 1 - k;
      logic [SW-1:0] dsk [D];

      // Early slices hold their partial sums until the top slice catches up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < D; j++) begin
            dsk[j] <= '0;
          end
        end else if (adv) begin
          dsk[0] <= sum_s[k];
          for (int j = 1; j < D; j++) begin
            dsk[j] <= dsk[j-1];
          end
        end
      end

      assign sum_aligned[k*SW +: SW] = dsk[D-1];
    end
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the single-stage 8-bit registered adder. Adds two WIDTH-bit operands plus carry-in by splitting the carry chain into STAGES equal slices, one slice per pipeline stage, with a valid/ready handshake and full backpressure. Sits in the datapath wherever a wide add must close timing at the system clock, and accepts one operation per cycle.

## Interface
- WIDTH, 8: operand and sum width in bits.
- STAGES, 2: pipeline depth, equal to the number of carry-chain slices. WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH; an illegal combination is an elaboration error.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow; present only with ADDER_OVERFLOW_EN.

## Operation
- Slice width is SW = WIDTH/STAGES. Stage k adds operand bits [k*SW +: SW] plus the carry registered by stage k-1. Stage 0 uses cin.
- Input skew: operand slice k is delayed k stages before its add, so it meets its carry.
- Output deskew: the result of slice k is delayed (STAGES-1-k) stages, so all sum bits, cout and ovf leave together.
- There is one pipeline advance enable: adv = !out_valid || out_ready. in_ready = adv.
- When adv is high, every stage register loads from its predecessor. The stage-0 valid loads in_valid.
- When adv is low, every register holds, including data and valid bits.
- A transfer occurs on a cycle when in_valid && in_ready. If in_valid is low while adv is high, a bubble (valid=0) is inserted.
- Arithmetic is unsigned and modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.
- Register contents are don't-care while their valid bit is 0. The bench checks sum and cout only when out_valid is high.
- Reset clears all valid bits and all data, carry and ovf registers to 0. Outputs during reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Reset mid-operation discards all in-flight operations. No partial result is ever emitted.

## Timing
- Latency is STAGES cycles. An operand accepted at edge N appears on sum/cout with out_valid=1 after edge N+STAGES-1. In other words, it is visible in the cycle that follows STAGES register loads.
- STAGES=1 reproduces a single registered adder with a handshake: result visible one cycle after acceptance.
- Throughput is one operation per cycle while out_ready is held high.
- in_ready depends combinationally on out_ready. There is no other combinational path from inputs to outputs.
- Under a stall (out_valid=1, out_ready=0), sum, cout and ovf must be stable until the handshake completes.
- Simultaneous accept and emit in the same cycle is the normal case and must lose nothing.

## Configuration
- ADDER_OVERFLOW_EN defined:
  - Port ovf exists.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last slice.
  - ovf is aligned with sum and reset to 0.
- ADDER_OVERFLOW_EN undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package adder_pkg holds:
  - DEFAULT_WIDTH = 8 and DEFAULT_STAGES = 2.
  - A function computing slice width.
  - The typedef of the per-stage carry/valid record.
- Sub-module adder_slice is instantiated STAGES times. It contains:
  - One SW-bit add with carry-in.
  - The registered carry and sum.
  - Ports for enable and reset.
- Skew and deskew registers live in pipelined_adder as generate loops.

## Test plan
- Basic (WIDTH=8, STAGES=2, out_ready=1): a=8'h55, b=8'hAA, cin=0 -> sum=8'hFF, cout=0, two cycles after acceptance.
- Cross-slice carry: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Streaming: send 6 back-to-back vectors (00+00, 01+01, 55+AA, FF+01, FF+FF+1, 3C+C3) -> results in order, one per cycle, with no gaps.
- Backpressure: hold out_ready=0 for 3 cycles while streaming. Required response:
  - in_ready=0 throughout.
  - sum is stable throughout.
  - No vector is lost or duplicated after release.
- Reset mid-flight: assert rst_n=0 with 2 operations in flight. Required response:
  - out_valid=0 immediately, asynchronously.
  - sum=0, in_ready=1.
  - After release, no stale result appears.
- Overflow (ADDER_OVERFLOW_EN): 8'h7F+8'h01 -> sum=8'h80, ovf=1. 8'h80+8'hFF -> sum=8'h7F, cout=1, ovf=1. Repeat the streaming test with WIDTH=32, STAGES=4 and random vectors checked against a reference model.
